// File: rtl/kd_node_pkg.sv
// Shared command encodings, controller states and axis helper for kd-tree node controllers.
package kd_node_pkg;

    localparam int unsigned CMD_W = 5;

    localparam logic [CMD_W-1:0] CmdNop                   = 5'd0;
    localparam logic [CMD_W-1:0] CmdRst                   = 5'd1;
    localparam logic [CMD_W-1:0] CmdRstDone               = 5'd2;
    localparam logic [CMD_W-1:0] CmdCenterFill            = 5'd3;
    localparam logic [CMD_W-1:0] CmdConfigureSortAxis     = 5'd4;
    localparam logic [CMD_W-1:0] CmdReceiveCenter         = 5'd5;
    localparam logic [CMD_W-1:0] CmdCenterFillDone        = 5'd6;
    localparam logic [CMD_W-1:0] CmdConfigureSortAxisDone = 5'd7;
    localparam logic [CMD_W-1:0] CmdBusy                  = 5'd8;
    localparam logic [CMD_W-1:0] CmdDne                   = 5'd9;

    typedef enum logic [2:0] {
        StIdle,
        StRstFwd,
        StFill,
        StFillWait,
        StAxis,
        StXchgTop,
        StXchgChild,
        StHold
    } kd_state_e;

    // Axis handed to the next tree level, wrapping dim-1 back to 0.
    function automatic int unsigned next_axis(input int unsigned axis, input int unsigned dim);
        return (axis + 1 >= dim) ? 0 : axis + 1;
    endfunction

endpackage

// File: rtl/kd_child_join.sv
// Sticky completion join over the (up to) two children of a node; absent children count as done.
module kd_child_join #(
    parameter bit LEFT_EN  = 1'b1,
    parameter bit RIGHT_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    input  logic left_hit_i,
    input  logic right_hit_i,
    output logic all_done_o
);

    logic [1:0] done_q, done_d;

    // Marks accumulate while the wait is active and are dropped once it is left.
    always_comb begin
        done_d = active_i ? (done_q | {right_hit_i, left_hit_i}) : 2'b00;
    end

    // A hit in the current cycle already counts, so the parent reacts on the same edge.
    always_comb begin
        all_done_o = active_i
                     && (done_q[0] || left_hit_i  || !LEFT_EN)
                     && (done_q[1] || right_hit_i || !RIGHT_EN);
    end

    // Sticky flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 2'b00;
        end else begin
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/kd_node_ctrl.sv
// kd-tree node controller: reset propagation, center fill, axis setup and center exchange.
module kd_node_ctrl
    import kd_node_pkg::*;
#(
    parameter int unsigned  DIM         = 3,
    parameter int unsigned  COORD_W     = 8,
    parameter int unsigned  LEFT_N      = 1,
    parameter int unsigned  RIGHT_N     = 1,
    parameter int unsigned  AXIS_ROTATE = 1,
    localparam int unsigned DATA_W      = DIM * COORD_W,
    localparam int unsigned AXIS_W      = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CMD_W-1:0]  command_from_top,
    input  logic [CMD_W-1:0]  command_from_left,
    input  logic [CMD_W-1:0]  command_from_right,
    input  logic [DATA_W-1:0] data_from_top,
    input  logic [DATA_W-1:0] data_from_left,
    input  logic [DATA_W-1:0] data_from_right,
    output logic [CMD_W-1:0]  command_to_top,
    output logic [CMD_W-1:0]  command_to_left,
    output logic [CMD_W-1:0]  command_to_right,
    output logic [DATA_W-1:0] data_to_top,
    output logic [DATA_W-1:0] data_to_left,
    output logic [DATA_W-1:0] data_to_right,
    input  logic              swap_left_req,
    input  logic              swap_right_req,
    output logic [DATA_W-1:0] center,
    output logic [AXIS_W-1:0] sorting_axis,
    output logic              swap_done
);

    localparam bit          LEFT_EN  = (LEFT_N != 0);
    localparam bit          RIGHT_EN = (RIGHT_N != 0);
    localparam int unsigned CNT_W    = $clog2(LEFT_N + RIGHT_N + 2);
    localparam logic [CNT_W-1:0] LEFT_K  = CNT_W'(LEFT_N);
    localparam logic [CNT_W-1:0] SPLIT_K = CNT_W'(LEFT_N + RIGHT_N);

    kd_state_e         state_q, state_d;
    logic [DATA_W-1:0] center_q, center_d;
    logic [AXIS_W-1:0] axis_q, axis_d;
    logic [CNT_W-1:0]  k_q, k_d;
    logic              sel_right_q, sel_right_d;
    logic [CMD_W-1:0]  cmd_top_q, cmd_top_d, cmd_left_q, cmd_left_d, cmd_right_q, cmd_right_d;
    logic [DATA_W-1:0] data_top_q, data_top_d, data_left_q, data_left_d;
    logic [DATA_W-1:0] data_right_q, data_right_d;
    logic              swap_done_q, swap_done_d;

    logic              rst_all_done, fill_all_done, axis_all_done;
    logic              preempt, fill_word;
    logic [AXIS_W-1:0] axis_in, rot_axis;

    assign axis_in  = AXIS_W'(32'(data_from_top[AXIS_W-1:0]) % DIM);
    assign rot_axis = (AXIS_ROTATE != 0) ? AXIS_W'(next_axis(32'(axis_q), DIM)) : axis_q;

    // A top rst restarts the node, except while the rst_done reply is still being held.
    assign preempt   = (command_from_top == CmdRst) && (state_q != StRstFwd)
                       && !((state_q == StHold) && (cmd_top_q == CmdRstDone));
    assign fill_word = (command_from_top == CmdCenterFill)
                       && ((state_q == StIdle) || (state_q == StFill));

    kd_child_join #(.LEFT_EN(LEFT_EN), .RIGHT_EN(RIGHT_EN)) u_rst_join (
        .clk         (clk),
        .rst         (rst),
        .active_i    (state_q == StRstFwd),
        .left_hit_i  (command_from_left == CmdRstDone),
        .right_hit_i (command_from_right == CmdRstDone),
        .all_done_o  (rst_all_done)
    );

    kd_child_join #(.LEFT_EN(LEFT_EN), .RIGHT_EN(RIGHT_EN)) u_fill_join (
        .clk         (clk),
        .rst         (rst),
        .active_i    ((state_q == StFill) || (state_q == StFillWait)),
        .left_hit_i  (command_from_left == CmdCenterFillDone),
        .right_hit_i (command_from_right == CmdCenterFillDone),
        .all_done_o  (fill_all_done)
    );

    kd_child_join #(.LEFT_EN(LEFT_EN), .RIGHT_EN(RIGHT_EN)) u_axis_join (
        .clk         (clk),
        .rst         (rst),
        .active_i    (state_q == StAxis),
        .left_hit_i  (command_from_left == CmdConfigureSortAxisDone),
        .right_hit_i (command_from_right == CmdConfigureSortAxisDone),
        .all_done_o  (axis_all_done)
    );

    // Next-state and next-output logic; channel outputs default to nop/0 every cycle.
    always_comb begin
        state_d      = state_q;
        center_d     = center_q;
        axis_d       = axis_q;
        k_d          = k_q;
        sel_right_d  = sel_right_q;
        cmd_top_d    = CmdNop;
        data_top_d   = '0;
        cmd_left_d   = CmdNop;
        data_left_d  = '0;
        cmd_right_d  = CmdNop;
        data_right_d = '0;
        swap_done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (command_from_top == CmdCenterFill) begin
                    state_d = StFill;
                end else if (command_from_top == CmdConfigureSortAxis) begin
                    axis_d  = axis_in;
                    state_d = StAxis;
                end else if (command_from_top == CmdReceiveCenter) begin
                    cmd_top_d   = CmdReceiveCenter;
                    data_top_d  = center_q;
                    center_d    = data_from_top;
                    cmd_left_d  = CmdBusy;
                    cmd_right_d = CmdBusy;
                    state_d     = StXchgTop;
                end else if (command_from_top == CmdNop && swap_left_req && LEFT_EN) begin
                    sel_right_d = 1'b0;
                    cmd_left_d  = CmdReceiveCenter;
                    data_left_d = center_q;
                    cmd_top_d   = CmdBusy;
                    state_d     = StXchgChild;
                end else if (command_from_top == CmdNop && swap_right_req && RIGHT_EN) begin
                    sel_right_d  = 1'b1;
                    cmd_right_d  = CmdReceiveCenter;
                    data_right_d = center_q;
                    cmd_top_d    = CmdBusy;
                    state_d      = StXchgChild;
                end
            end
            StRstFwd: begin
                if (rst_all_done) begin
                    center_d  = '0;
                    axis_d    = '0;
                    cmd_top_d = CmdRstDone;
                    state_d   = StHold;
                end else begin
                    cmd_left_d  = CmdRst;
                    cmd_right_d = CmdRst;
                end
            end
            StFill: ;
            StFillWait: begin
                if (fill_all_done) begin
                    cmd_top_d = CmdCenterFillDone;
                    state_d   = StHold;
                end
            end
            StAxis: begin
                if (axis_all_done) begin
                    cmd_top_d = CmdConfigureSortAxisDone;
                    state_d   = StHold;
                end else begin
                    cmd_left_d   = CmdConfigureSortAxis;
                    cmd_right_d  = CmdConfigureSortAxis;
                    data_left_d  = DATA_W'(rot_axis);
                    data_right_d = DATA_W'(rot_axis);
                end
            end
            StXchgChild: begin
                cmd_top_d = CmdBusy;
                if (!sel_right_q) begin
                    if (command_from_left == CmdReceiveCenter) begin
                        center_d    = data_from_left;
                        cmd_top_d   = CmdNop;
                        swap_done_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        cmd_left_d  = CmdReceiveCenter;
                        data_left_d = center_q;
                    end
                end else begin
                    if (command_from_right == CmdReceiveCenter) begin
                        center_d    = data_from_right;
                        cmd_top_d   = CmdNop;
                        swap_done_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        cmd_right_d  = CmdReceiveCenter;
                        data_right_d = center_q;
                    end
                end
            end
            StXchgTop, StHold: begin
                if (state_q == StXchgTop || command_from_top != CmdNop) begin
                    cmd_top_d    = cmd_top_q;
                    data_top_d   = data_top_q;
                    cmd_left_d   = cmd_left_q;
                    data_left_d  = data_left_q;
                    cmd_right_d  = cmd_right_q;
                    data_right_d = data_right_q;
                    state_d      = StHold;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Fill routing by word index: left subtree, then right subtree, then own center.
        if (fill_word) begin
            if (k_q < LEFT_K) begin
                cmd_left_d  = CmdCenterFill;
                data_left_d = data_from_top;
                k_d         = k_q + CNT_W'(1);
            end else if (k_q < SPLIT_K) begin
                cmd_right_d  = CmdCenterFill;
                data_right_d = data_from_top;
                k_d          = k_q + CNT_W'(1);
            end else begin
                center_d = data_from_top;
                k_d      = '0;
                state_d  = StFillWait;
            end
        end

        if (preempt) begin
            center_d     = center_q;
            axis_d       = axis_q;
            k_d          = '0;
            cmd_top_d    = CmdNop;
            data_top_d   = '0;
            data_left_d  = '0;
            data_right_d = '0;
            swap_done_d  = 1'b0;
            if (LEFT_EN || RIGHT_EN) begin
                cmd_left_d  = CmdRst;
                cmd_right_d = CmdRst;
                state_d     = StRstFwd;
            end else begin
                // A leaf has nobody to wait for.
                center_d    = '0;
                axis_d      = '0;
                cmd_left_d  = CmdNop;
                cmd_right_d = CmdNop;
                cmd_top_d   = CmdRstDone;
                state_d     = StHold;
            end
        end

        if (!LEFT_EN) begin
            cmd_left_d  = CmdNop;
            data_left_d = '0;
        end
        if (!RIGHT_EN) begin
            cmd_right_d  = CmdNop;
            data_right_d = '0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            center_q     <= '0;
            axis_q       <= '0;
            k_q          <= '0;
            sel_right_q  <= 1'b0;
            cmd_top_q    <= CmdNop;
            data_top_q   <= '0;
            cmd_left_q   <= CmdNop;
            data_left_q  <= '0;
            cmd_right_q  <= CmdNop;
            data_right_q <= '0;
            swap_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            center_q     <= center_d;
            axis_q       <= axis_d;
            k_q          <= k_d;
            sel_right_q  <= sel_right_d;
            cmd_top_q    <= cmd_top_d;
            data_top_q   <= data_top_d;
            cmd_left_q   <= cmd_left_d;
            data_left_q  <= data_left_d;
            cmd_right_q  <= cmd_right_d;
            data_right_q <= data_right_d;
            swap_done_q  <= swap_done_d;
        end
    end

    assign command_to_top   = cmd_top_q;
    assign data_to_top      = data_top_q;
    assign command_to_left  = cmd_left_q;
    assign data_to_left     = data_left_q;
    assign command_to_right = cmd_right_q;
    assign data_to_right    = data_right_q;
    assign center           = center_q;
    assign sorting_axis     = axis_q;
    assign swap_done        = swap_done_q;

endmodule

// File: tb/tb_kd_node_ctrl.sv
// Directed bench for kd_node_ctrl: a two-child node and a leaf, checked every cycle.
module tb_kd_node_ctrl;
    import kd_node_pkg::*;

    localparam int unsigned DW = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // two-child node
    logic [4:0]    top_cmd, l_cmd, r_cmd;
    logic [DW-1:0] top_data, l_data, r_data;
    logic          swap_l, swap_r;
    logic [4:0]    o_top_cmd, o_l_cmd, o_r_cmd;
    logic [DW-1:0] o_top_data, o_l_data, o_r_data, o_center;
    logic [1:0]    o_axis;
    logic          o_swap;

    // leaf node
    logic [4:0]    lf_top_cmd, lf_junk_cmd;
    logic [DW-1:0] lf_top_data, lf_junk_data;
    logic          lf_swap_l, lf_swap_r;
    logic [4:0]    lo_top_cmd, lo_l_cmd, lo_r_cmd;
    logic [DW-1:0] lo_top_data, lo_l_data, lo_r_data, lo_center;
    logic [1:0]    lo_axis;
    logic          lo_swap;

    // expectations: model state plus expected channel traffic
    logic [DW-1:0] m_center, f_center;
    logic [1:0]    m_axis, f_axis;
    logic [4:0]    e_top_cmd, e_l_cmd, e_r_cmd, f_top_cmd;
    logic [DW-1:0] e_top_data, e_l_data, e_r_data, f_top_data;
    logic          e_swap;
    logic          chk_en;
    int            n_cmp = 0;
    int            n_bad = 0;

    kd_node_ctrl #(.DIM(3), .COORD_W(8), .LEFT_N(1), .RIGHT_N(1), .AXIS_ROTATE(1)) dut (
        .clk(clk), .rst(rst),
        .command_from_top(top_cmd), .command_from_left(l_cmd), .command_from_right(r_cmd),
        .data_from_top(top_data), .data_from_left(l_data), .data_from_right(r_data),
        .command_to_top(o_top_cmd), .command_to_left(o_l_cmd), .command_to_right(o_r_cmd),
        .data_to_top(o_top_data), .data_to_left(o_l_data), .data_to_right(o_r_data),
        .swap_left_req(swap_l), .swap_right_req(swap_r),
        .center(o_center), .sorting_axis(o_axis), .swap_done(o_swap)
    );

    kd_node_ctrl #(.DIM(3), .COORD_W(8), .LEFT_N(0), .RIGHT_N(0), .AXIS_ROTATE(1)) leaf (
        .clk(clk), .rst(rst),
        .command_from_top(lf_top_cmd), .command_from_left(lf_junk_cmd),
        .command_from_right(lf_junk_cmd),
        .data_from_top(lf_top_data), .data_from_left(lf_junk_data),
        .data_from_right(lf_junk_data),
        .command_to_top(lo_top_cmd), .command_to_left(lo_l_cmd), .command_to_right(lo_r_cmd),
        .data_to_top(lo_top_data), .data_to_left(lo_l_data), .data_to_right(lo_r_data),
        .swap_left_req(lf_swap_l), .swap_right_req(lf_swap_r),
        .center(lo_center), .sorting_axis(lo_axis), .swap_done(lo_swap)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit carries(input logic [4:0] c);
        return c == CmdCenterFill || c == CmdConfigureSortAxis || c == CmdReceiveCenter;
    endfunction

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("top_cmd", 32'(o_top_cmd), 32'(e_top_cmd));
            if (carries(e_top_cmd)) chk("top_data", 32'(o_top_data), 32'(e_top_data));
            chk("left_cmd", 32'(o_l_cmd), 32'(e_l_cmd));
            if (carries(e_l_cmd)) chk("left_data", 32'(o_l_data), 32'(e_l_data));
            chk("right_cmd", 32'(o_r_cmd), 32'(e_r_cmd));
            if (carries(e_r_cmd)) chk("right_data", 32'(o_r_data), 32'(e_r_data));
            chk("center", 32'(o_center), 32'(m_center));
            chk("axis", 32'(o_axis), 32'(m_axis));
            chk("swap_done", 32'(o_swap), 32'(e_swap));
            chk("leaf_top_cmd", 32'(lo_top_cmd), 32'(f_top_cmd));
            if (carries(f_top_cmd)) chk("leaf_top_data", 32'(lo_top_data), 32'(f_top_data));
            chk("leaf_left_cmd", 32'(lo_l_cmd), 32'(CmdNop));
            chk("leaf_left_data", 32'(lo_l_data), 32'd0);
            chk("leaf_right_cmd", 32'(lo_r_cmd), 32'(CmdNop));
            chk("leaf_center", 32'(lo_center), 32'(f_center));
            chk("leaf_axis", 32'(lo_axis), 32'(f_axis));
            chk("leaf_swap_done", 32'(lo_swap), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle();
        e_top_cmd = CmdNop; e_top_data = '0;
        e_l_cmd = CmdNop; e_l_data = '0;
        e_r_cmd = CmdNop; e_r_data = '0;
        e_swap = 1'b0;
    endtask

    // Stream three words; children answer done one cycle apart.
    task automatic fill3(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                         input logic [DW-1:0] w2);
        top_cmd = CmdCenterFill; top_data = w0; tick();
        exp_idle(); e_l_cmd = CmdCenterFill; e_l_data = w0;
        top_data = w1; tick();
        exp_idle(); e_r_cmd = CmdCenterFill; e_r_data = w1;
        top_data = w2; tick();
        exp_idle(); m_center = w2;
        top_data = '0; l_cmd = CmdCenterFillDone; tick();
        exp_idle();
        l_cmd = CmdNop; r_cmd = CmdCenterFillDone; tick();
        exp_idle(); e_top_cmd = CmdCenterFillDone;
        r_cmd = CmdNop; tick();
        top_cmd = CmdNop; tick();
        exp_idle();
    endtask

    task automatic axis_cfg(input logic [DW-1:0] v);
        top_cmd = CmdConfigureSortAxis; top_data = v; tick();
        exp_idle(); m_axis = 2'(32'(v[1:0]) % 3);
        tick();
        exp_idle();
        e_l_cmd = CmdConfigureSortAxis; e_r_cmd = CmdConfigureSortAxis;
        e_l_data = DW'((32'(m_axis) + 1) % 3); e_r_data = e_l_data;
        l_cmd = CmdConfigureSortAxisDone; r_cmd = CmdConfigureSortAxisDone; tick();
        exp_idle(); e_top_cmd = CmdConfigureSortAxisDone;
        l_cmd = CmdNop; r_cmd = CmdNop; tick();
        top_cmd = CmdNop; tick();
        exp_idle();
    endtask

    initial begin
        rst = 1'b1; chk_en = 1'b0;
        top_cmd = CmdNop; l_cmd = CmdNop; r_cmd = CmdNop;
        top_data = '0; l_data = '0; r_data = '0; swap_l = 1'b0; swap_r = 1'b0;
        lf_top_cmd = CmdNop; lf_top_data = '0; lf_swap_l = 1'b0; lf_swap_r = 1'b0;
        lf_junk_cmd = CmdReceiveCenter; lf_junk_data = 24'h5A5A5A;
        m_center = '0; m_axis = '0; f_center = '0; f_axis = '0;
        f_top_cmd = CmdNop; f_top_data = '0;
        exp_idle();
        tick(); tick();
        rst = 1'b0; chk_en = 1'b1;
        chk("reset_center", 32'(o_center), 32'd0);
        chk("reset_top_cmd", 32'(o_top_cmd), 32'(CmdNop));
        tick();

        fill3(24'h010203, 24'h040506, 24'h070809);
        chk("fill_center_lit", 32'(o_center), 32'h070809);

        axis_cfg(24'd3);
        axis_cfg(24'd2);
        chk("axis_lit", 32'(o_axis), 32'd2);

        // rst propagation: staggered child replies, reply held while top stays rst
        top_cmd = CmdRst; tick();
        exp_idle(); e_l_cmd = CmdRst; e_r_cmd = CmdRst;
        l_cmd = CmdRstDone; tick();
        l_cmd = CmdNop; r_cmd = CmdRstDone; tick();
        exp_idle(); e_top_cmd = CmdRstDone; m_center = '0; m_axis = '0;
        r_cmd = CmdNop; tick();
        top_cmd = CmdNop; tick();
        exp_idle();
        chk("rstfwd_center_lit", 32'(o_center), 32'd0);

        // hard reset mid-fill, then a fresh fill
        fill3(24'h0A0B0C, 24'h0D0E0F, 24'h101112);
        top_cmd = CmdCenterFill; top_data = 24'h212223; tick();
        exp_idle(); e_l_cmd = CmdCenterFill; e_l_data = 24'h212223;
        rst = 1'b1; top_data = 24'h242526; tick();
        exp_idle(); m_center = '0; m_axis = '0; f_center = '0;
        chk("rst_mid_fill_center", 32'(o_center), 32'd0);
        rst = 1'b0; top_cmd = CmdNop; tick();
        fill3(24'h0000AA, 24'h0000BB, 24'h111111);

        // exchange with parent
        top_cmd = CmdReceiveCenter; top_data = 24'h222222; tick();
        exp_idle(); e_top_cmd = CmdReceiveCenter; e_top_data = 24'h111111;
        e_l_cmd = CmdBusy; e_r_cmd = CmdBusy; m_center = 24'h222222;
        chk("xchg_top_data_lit", 32'(o_top_data), 32'h111111);
        tick();
        top_cmd = CmdNop; tick();
        exp_idle();

        // child swap: both requests together, left wins, right is dropped
        fill3(24'h0000CC, 24'h0000DD, 24'h333333);
        swap_l = 1'b1; swap_r = 1'b1; tick();
        exp_idle(); e_l_cmd = CmdReceiveCenter; e_l_data = 24'h333333; e_top_cmd = CmdBusy;
        swap_l = 1'b0; swap_r = 1'b0; tick();
        l_cmd = CmdReceiveCenter; l_data = 24'h444444; tick();
        exp_idle(); m_center = 24'h444444; e_swap = 1'b1;
        chk("swap_center_lit", 32'(o_center), 32'h444444);
        l_cmd = CmdNop; l_data = '0; tick();
        exp_idle();
        tick(); tick();

        // leaf: fill, axis, rst, swap requests with no children
        lf_top_cmd = CmdCenterFill; lf_top_data = 24'hAABBCC; tick();
        f_center = 24'hAABBCC;
        chk("leaf_fill_lit", 32'(lo_center), 32'hAABBCC);
        tick();
        f_top_cmd = CmdCenterFillDone;
        lf_top_cmd = CmdNop; tick();
        f_top_cmd = CmdNop;
        lf_top_cmd = CmdConfigureSortAxis; lf_top_data = 24'd2; tick();
        f_axis = 2'd2;
        tick();
        f_top_cmd = CmdConfigureSortAxisDone;
        lf_top_cmd = CmdNop; tick();
        f_top_cmd = CmdNop;
        lf_top_cmd = CmdRst; tick();
        f_top_cmd = CmdRstDone; f_center = '0; f_axis = '0;
        lf_top_cmd = CmdNop; tick();
        f_top_cmd = CmdNop;
        lf_swap_l = 1'b1; lf_swap_r = 1'b1; tick();
        lf_swap_l = 1'b0; lf_swap_r = 1'b0; tick();
        tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
